neurosa_run_sequencer: RTL and testbench

//  Host-facing run controller for the top_neurons array. On start it resets the array, programs the active-neuron count,

---
 rtl/neurosa_run_sequencer_pkg.sv | 42 ++++
 rtl/neurosa_run_sequencer_if.sv | 49 ++++
 rtl/neurosa_run_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_neurosa_run_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/neurosa_run_sequencer_pkg.sv
// Shared types and constants for the neurosa run sequencer.
package neurosa_pkg;

    localparam int FP_DATA_WIDTH_DEF   = 16;
    localparam int NEURON_ID_WIDTH_DEF = 8;
    localparam int ITER_WIDTH_DEF      = 16;
    localparam int PERIOD_WIDTH_DEF    = 16;
    localparam int READ_TIMEOUT_DEF    = 64;

    // Config words streamed per neuron: Vmem, mu, neuronI, Q.
    localparam int WORDS_PER_NEURON = 4;
    // Cycles the array is held in reset after an accepted start.
    localparam int ARST_CYCLES      = 2;
    // Begin-write marker; sliced to the array bus width at the point of use.
    localparam logic [63:0] BEGIN_WR = '1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARST,
        S_SETUP,
        S_BEGIN,
        S_LOAD,
        S_RUN,
        S_RDREQ,
        S_READ,
        S_DONE
    } seq_state_t;

    // ABORT shares code 1 with BAD_ARG.
    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BAD_ARG  = 2'd1,
        ERR_UNDERRUN = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_t;

    // Index of the final config word for a given active-neuron count.
    function automatic int last_word_idx(input int n);
        return n * WORDS_PER_NEURON - 1;
    endfunction

endpackage

// File: rtl/neurosa_run_sequencer_if.sv
// Host, config, array and result signals of the run sequencer, bundled.
interface neurosa_run_sequencer_if #(
    parameter int FP_DATA_WIDTH   = 16,
    parameter int NEURON_ID_WIDTH = 8,
    parameter int ITER_WIDTH      = 16,
    parameter int PERIOD_WIDTH    = 16
);
    logic                       start;
    logic                       abort;
    logic [NEURON_ID_WIDTH-1:0] num_active;
    logic [ITER_WIDTH-1:0]      num_iters;
    logic [PERIOD_WIDTH-1:0]    read_period;
    logic                       cfg_valid;
    logic                       cfg_ready;
    logic [FP_DATA_WIDTH-1:0]   cfg_data;
    logic                       arr_reset_l;
    logic [FP_DATA_WIDTH-1:0]   arr_ins;
    logic                       arr_rd;
    logic [FP_DATA_WIDTH-1:0]   arr_outs;
    logic                       arr_read_done;
    logic                       res_valid;
    logic [FP_DATA_WIDTH-1:0]   res_data;
    logic [NEURON_ID_WIDTH-1:0] res_idx;
    logic                       res_last;
    logic [ITER_WIDTH-1:0]      iter_count;
    logic                       busy;
    logic                       done;
    logic                       err;
    logic [1:0]                 err_code;

    // Sequencer side.
    modport master (
        input  start, abort, num_active, num_iters, read_period,
               cfg_valid, cfg_data, arr_outs, arr_read_done,
        output cfg_ready, arr_reset_l, arr_ins, arr_rd,
               res_valid, res_data, res_idx, res_last,
               iter_count, busy, done, err, err_code
    );

    // Host / array side.
    modport slave (
        output start, abort, num_active, num_iters, read_period,
               cfg_valid, cfg_data, arr_outs, arr_read_done,
        input  cfg_ready, arr_reset_l, arr_ins, arr_rd,
               res_valid, res_data, res_idx, res_last,
               iter_count, busy, done, err, err_code
    );

endinterface

// File: rtl/neurosa_run_sequencer.sv
// Run controller for the top_neurons array: reset, program, load config,
// then alternate RUN epochs with readout bursts forwarded to the host.
// Control outputs (busy, cfg_ready, arr_rd, arr_reset_l, done) follow the
// state; the array data bus and result stream are registered images of the
// current cycle's payload, so they trail the state by one cycle. This keeps
// the array bus contiguous: N, BEGIN_WR, then the config words back to back.
module neurosa_run_sequencer
    import neurosa_pkg::*;
#(
    parameter int FP_DATA_WIDTH   = FP_DATA_WIDTH_DEF,
    parameter int NEURON_ID_WIDTH = NEURON_ID_WIDTH_DEF,
    parameter int ITER_WIDTH      = ITER_WIDTH_DEF,
    parameter int PERIOD_WIDTH    = PERIOD_WIDTH_DEF,
    parameter int READ_TIMEOUT    = READ_TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    neurosa_run_sequencer_if.master  bus
);

    localparam int WCNT_W = NEURON_ID_WIDTH + 2;

    seq_state_t                 r_state, w_state_next;
    logic [NEURON_ID_WIDTH-1:0] r_num_active;
    logic [ITER_WIDTH-1:0]      r_num_iters;
    logic [PERIOD_WIDTH-1:0]    r_read_period;
    logic [PERIOD_WIDTH-1:0]    r_cyc_cnt, w_cyc_next;
    logic [WCNT_W-1:0]          r_word_cnt, w_word_next, w_last_word;
    logic [ITER_WIDTH-1:0]      r_iter_count, w_iter_next, w_iter_inc;
    logic                       r_err, w_err_next;
    err_code_t                  r_err_code, w_err_code_next;
    logic [FP_DATA_WIDTH-1:0]   r_arr_ins, w_arr_ins_next;
    logic                       r_res_valid, w_res_valid_next;
    logic [FP_DATA_WIDTH-1:0]   r_res_data, w_res_data_next;
    logic [NEURON_ID_WIDTH-1:0] r_res_idx, w_res_idx_next;
    logic                       r_res_last, w_res_last_next;
    logic                       w_latch_args;
    logic                       r_busy, r_done, r_cfg_ready, r_arr_rd, r_arr_reset_l;

    assign w_last_word = WCNT_W'(last_word_idx(int'(r_num_active)));
    assign w_iter_inc  = r_iter_count + ITER_WIDTH'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state, counter and payload decode.
    always_comb begin
        w_state_next     = r_state;
        w_cyc_next       = r_cyc_cnt;
        w_word_next      = r_word_cnt;
        w_iter_next      = r_iter_count;
        w_err_next       = r_err;
        w_err_code_next  = r_err_code;
        w_arr_ins_next   = '0;
        w_res_valid_next = 1'b0;
        w_res_data_next  = '0;
        w_res_idx_next   = '0;
        w_res_last_next  = 1'b0;
        w_latch_args     = 1'b0;
        if (bus.abort && (r_state != S_IDLE)) begin
            w_state_next    = S_IDLE;
            w_err_next      = 1'b1;
            w_err_code_next = ERR_BAD_ARG;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if ((bus.num_active == '0) || (bus.num_iters == '0) ||
                            (bus.read_period == '0)) begin
                            w_err_next      = 1'b1;
                            w_err_code_next = ERR_BAD_ARG;
                        end else begin
                            w_state_next    = S_ARST;
                            w_cyc_next      = '0;
                            w_iter_next     = '0;
                            w_err_next      = 1'b0;
                            w_err_code_next = ERR_NONE;
                            w_latch_args    = 1'b1;
                        end
                    end
                end
                S_ARST: begin
                    if (r_cyc_cnt == PERIOD_WIDTH'(ARST_CYCLES - 1)) w_state_next = S_SETUP;
                    else                                               w_cyc_next   = r_cyc_cnt + PERIOD_WIDTH'(1);
                end
                S_SETUP: begin
                    w_arr_ins_next = FP_DATA_WIDTH'(r_num_active);
                    w_state_next   = S_BEGIN;
                end
                S_BEGIN: begin
                    w_arr_ins_next = BEGIN_WR[FP_DATA_WIDTH-1:0];
                    w_word_next    = '0;
                    w_state_next   = S_LOAD;
                end
                S_LOAD: begin
                    // The array consumes one word per cycle and cannot stall.
                    if (!bus.cfg_valid) begin
                        w_state_next    = S_IDLE;
                        w_err_next      = 1'b1;
                        w_err_code_next = ERR_UNDERRUN;
                    end else begin
                        w_arr_ins_next = bus.cfg_data;
                        if (r_word_cnt == w_last_word) begin
                            w_state_next = S_RUN;
                            w_cyc_next   = '0;
                        end else begin
                            w_word_next  = r_word_cnt + WCNT_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (r_cyc_cnt == r_read_period - PERIOD_WIDTH'(1)) w_state_next = S_RDREQ;
                    else                                              w_cyc_next   = r_cyc_cnt + PERIOD_WIDTH'(1);
                end
                S_RDREQ: begin
                    w_state_next = S_READ;
                    w_cyc_next   = '0;
                end
                S_READ: begin
                    w_res_valid_next = 1'b1;
                    w_res_data_next  = bus.arr_outs;
                    w_res_idx_next   = r_res_valid ? r_res_idx + NEURON_ID_WIDTH'(1) : '0;
                    if (bus.arr_read_done) begin
                        w_res_last_next = 1'b1;
                        w_iter_next     = w_iter_inc;
                        w_cyc_next      = '0;
                        w_state_next    = (w_iter_inc == r_num_iters) ? S_DONE : S_RUN;
                    end else if (r_cyc_cnt == PERIOD_WIDTH'(READ_TIMEOUT - 1)) begin
                        w_state_next    = S_IDLE;
                        w_err_next      = 1'b1;
                        w_err_code_next = ERR_TIMEOUT;
                    end else begin
                        w_cyc_next = r_cyc_cnt + PERIOD_WIDTH'(1);
                    end
                end
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Counters, sampled arguments and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_num_active  <= '0;
            r_num_iters   <= '0;
            r_read_period <= '0;
            r_cyc_cnt     <= '0;
            r_word_cnt    <= '0;
            r_iter_count  <= '0;
            r_err         <= 1'b0;
            r_err_code    <= ERR_NONE;
            r_arr_ins     <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_idx     <= '0;
            r_res_last    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_cfg_ready   <= 1'b0;
            r_arr_rd      <= 1'b0;
            r_arr_reset_l <= 1'b0;
        end else begin
            if (w_latch_args) begin
                r_num_active  <= bus.num_active;
                r_num_iters   <= bus.num_iters;
                r_read_period <= bus.read_period;
            end
            r_cyc_cnt     <= w_cyc_next;
            r_word_cnt    <= w_word_next;
            r_iter_count  <= w_iter_next;
            r_err         <= w_err_next;
            r_err_code    <= w_err_code_next;
            r_arr_ins     <= w_arr_ins_next;
            r_res_valid   <= w_res_valid_next;
            r_res_data    <= w_res_data_next;
            r_res_idx     <= w_res_idx_next;
            r_res_last    <= w_res_last_next;
            r_busy        <= (w_state_next != S_IDLE);
            r_done        <= (w_state_next == S_DONE);
            r_cfg_ready   <= (w_state_next == S_LOAD);
            r_arr_rd      <= (w_state_next == S_RDREQ);
            r_arr_reset_l <= (w_state_next != S_IDLE) && (w_state_next != S_ARST);
        end
    end

    assign bus.cfg_ready   = r_cfg_ready;
    assign bus.arr_reset_l = r_arr_reset_l;
    assign bus.arr_ins     = r_arr_ins;
    assign bus.arr_rd      = r_arr_rd;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_data    = r_res_data;
    assign bus.res_idx     = r_res_idx;
    assign bus.res_last    = r_res_last;
    assign bus.iter_count  = r_iter_count;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.err_code    = r_err_code;

endmodule

// File: tb/tb_neurosa_run_sequencer.sv
// Directed bench for neurosa_run_sequencer with a hand-driven array model.
module tb_neurosa_run_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    neurosa_run_sequencer_if #(
        .FP_DATA_WIDTH(16), .NEURON_ID_WIDTH(8), .ITER_WIDTH(16), .PERIOD_WIDTH(16)
    ) bus ();

    neurosa_run_sequencer #(
        .FP_DATA_WIDTH(16), .NEURON_ID_WIDTH(8), .ITER_WIDTH(16),
        .PERIOD_WIDTH(16), .READ_TIMEOUT(64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] word_pat(input int k);
        return 16'(16'h1000 + k * 259);
    endfunction

    function automatic logic [15:0] rd_pat(input int it, input int j);
        return 16'(16'hB000 + it * 16 + j);
    endfunction

    // Accepted start: ARST x2, SETUP, BEGIN, ending in the first LOAD cycle.
    task automatic start_seq(input int n, input int iters, input int period);
        bus.num_active  = 8'(n);
        bus.num_iters   = 16'(iters);
        bus.read_period = 16'(period);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        $display("start N=%0d iters=%0d period=%0d", n, iters, period);
        check_val("start_busy", bus.busy, 1);
        check_val("start_err_clr", bus.err, 0);
        check_val("start_code_clr", bus.err_code, 0);
        check_val("arst0_rstl", bus.arr_reset_l, 0);
        tick();
        check_val("arst1_rstl", bus.arr_reset_l, 0);
        tick();
        check_val("setup_rstl", bus.arr_reset_l, 1);
        check_val("setup_ins", bus.arr_ins, 0);
        tick();
        check_val("ins_num_active", bus.arr_ins, n);
        tick();
        check_val("ins_begin_wr", bus.arr_ins, 32'hFFFF);
        check_val("load_cfg_ready", bus.cfg_ready, 1);
    endtask

    task automatic load_words(input int count);
        for (int k = 0; k < count; k++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = word_pat(k);
            tick();
            check_val("ins_cfg_word", bus.arr_ins, word_pat(k));
        end
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
    endtask

    // From the first RUN cycle, count cycles until the rd pulse shows.
    task automatic wait_rd(input int exp_gap);
        int cnt = 0;
        while (bus.arr_rd !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        check_val("rd_gap", cnt, exp_gap);
    endtask

    // From the RDREQ cycle: drive k readout words, readDone on the last.
    task automatic read_burst(input int k, input bit last_iter, input int it);
        tick();
        check_val("rd_one_cycle", bus.arr_rd, 0);
        for (int j = 0; j < k; j++) begin
            bus.arr_outs      = rd_pat(it, j);
            bus.arr_read_done = (j == k - 1);
            tick();
            check_val("res_valid", bus.res_valid, 1);
            check_val("res_data", bus.res_data, rd_pat(it, j));
            check_val("res_idx", bus.res_idx, j);
            check_val("res_last", bus.res_last, (j == k - 1));
        end
        bus.arr_outs      = '0;
        bus.arr_read_done = 1'b0;
        $display("burst epoch=%0d words=%0d last=%0d", it, k, last_iter);
        check_val("iter_count", bus.iter_count, it + 1);
        check_val("done_pulse", bus.done, last_iter);
        if (last_iter) begin
            tick();
            check_val("done_clear", bus.done, 0);
            check_val("idle_busy", bus.busy, 0);
            check_val("idle_rstl", bus.arr_reset_l, 0);
            check_val("idle_res_valid", bus.res_valid, 0);
        end
    endtask

    initial begin
        int cnt;
        int words;
        bus.start = 1'b0; bus.abort = 1'b0; bus.num_active = '0; bus.num_iters = '0;
        bus.read_period = '0; bus.cfg_valid = 1'b0; bus.cfg_data = '0;
        bus.arr_outs = '0; bus.arr_read_done = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_err", bus.err, 0);
        check_val("rst_code", bus.err_code, 0);
        check_val("rst_rstl", bus.arr_reset_l, 0);
        check_val("rst_ins", bus.arr_ins, 0);
        check_val("rst_rd", bus.arr_rd, 0);
        check_val("rst_cfg_ready", bus.cfg_ready, 0);
        check_val("rst_res_valid", bus.res_valid, 0);
        check_val("rst_iter", bus.iter_count, 0);
        reset = 1'b0;
        tick();

        // N=4, 2 epochs of 8 cycles, one readout word per burst.
        start_seq(4, 2, 8);
        load_words(16);
        check_val("run_cfg_ready", bus.cfg_ready, 0);
        wait_rd(8);
        read_burst(1, 1'b0, 0);
        wait_rd(8);
        read_burst(1, 1'b1, 1);
        tick();
        check_val("iter_hold", bus.iter_count, 2);

        // Start with N=0 is refused in place.
        bus.num_active = 8'd0; bus.num_iters = 16'd1; bus.read_period = 16'd4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        $display("start N=0 (bad argument)");
        check_val("badarg_busy", bus.busy, 0);
        check_val("badarg_err", bus.err, 1);
        check_val("badarg_code", bus.err_code, 1);
        check_val("badarg_iter_hold", bus.iter_count, 2);

        // N=32, period 10, readDone on third word.
        start_seq(32, 1, 10);
        load_words(128);
        wait_rd(10);
        read_burst(3, 1'b1, 0);

        // Underrun: cfg_valid drops on word 5 with N=2.
        start_seq(2, 1, 4);
        load_words(5);
        tick();
        $display("underrun at word 5");
        check_val("underrun_err", bus.err, 1);
        check_val("underrun_code", bus.err_code, 2);
        check_val("underrun_busy", bus.busy, 0);
        check_val("underrun_rstl", bus.arr_reset_l, 0);
        check_val("underrun_cfg_ready", bus.cfg_ready, 0);

        // Read timeout: readDone never comes.
        start_seq(1, 1, 2);
        load_words(4);
        wait_rd(2);
        cnt = 0; words = 0;
        while (bus.busy === 1'b1 && cnt < 100) begin
            tick();
            cnt++;
            if (bus.res_valid === 1'b1) words++;
        end
        $display("timeout after %0d cycles, %0d words", cnt, words);
        check_val("timeout_cycles", cnt, 65);
        check_val("timeout_words", words, 64);
        check_val("timeout_err", bus.err, 1);
        check_val("timeout_code", bus.err_code, 3);

        // Abort while in RUN.
        start_seq(2, 1, 20);
        load_words(8);
        repeat (3) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        $display("abort in RUN");
        check_val("abort_busy", bus.busy, 0);
        check_val("abort_err", bus.err, 1);
        check_val("abort_code", bus.err_code, 1);
        check_val("abort_rstl", bus.arr_reset_l, 0);

        // Reset during LOAD.
        start_seq(2, 1, 5);
        load_words(3);
        bus.cfg_valid = 1'b1;
        reset = 1'b1;
        tick();
        $display("reset during LOAD");
        check_val("mrst_busy", bus.busy, 0);
        check_val("mrst_cfg_ready", bus.cfg_ready, 0);
        check_val("mrst_ins", bus.arr_ins, 0);
        check_val("mrst_rstl", bus.arr_reset_l, 0);
        check_val("mrst_err", bus.err, 0);
        check_val("mrst_code", bus.err_code, 0);
        check_val("mrst_iter", bus.iter_count, 0);
        check_val("mrst_res_valid", bus.res_valid, 0);
        bus.cfg_valid = 1'b0;
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
